// File: rtl/bus_arbit_rr_if.sv
// Request/grant bundle between bus masters and the round-robin arbiter.
//   m_req   : per-master request, level, held while the bus is wanted
//   m_lock  : per-master lock, suppresses preemption of the current owner
//   m_grant : one-hot (or zero) registered grant
//   m_owner : index of the granted master, last owner while idle
//   m_busy  : any grant active
// Modports: master = requesting side, slave = arbiter side.
interface bus_arbit_rr_if #(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned OWN_W    = 2
) ();
  logic [N_MASTER-1:0] m_req;
  logic [N_MASTER-1:0] m_lock;
  logic [N_MASTER-1:0] m_grant;
  logic [OWN_W-1:0]    m_owner;
  logic                m_busy;

  modport master (
    output m_req,
    output m_lock,
    input  m_grant,
    input  m_owner,
    input  m_busy
  );

  modport slave (
    input  m_req,
    input  m_lock,
    output m_grant,
    output m_owner,
    output m_busy
  );
endinterface

// File: rtl/bus_arbit_rr.sv
// Round-robin bus arbiter with a hold limit that forces rotation and a
// per-master lock that blocks that rotation.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : bus_arbit_rr_if.slave (m_req, m_lock in; m_grant, m_owner, m_busy out)
// All outputs come straight from flops; grant latency is one cycle.
module bus_arbit_rr #(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned OWN_W    = 2
) (
  input logic           clk,
  input logic           reset_n,
  bus_arbit_rr_if.slave bus
);

  localparam int unsigned HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;

  logic [2*N_MASTER-1:0] req_dbl;
  logic [2*N_MASTER-1:0] req_rot_full;
  logic [N_MASTER-1:0]   req_rot;
  logic [N_MASTER-1:0]   own_mask;
  logic                  own_req, own_lock, others;
  logic                  win_found;
  logic [OWN_W-1:0]      win_idx;
  logic                  take;
  int                    win_sum;

  // Rotate requests so bit 0 is master (last+1); doubled vector handles the wrap.
  always_comb begin
    req_dbl      = {bus.m_req, bus.m_req};
    req_rot_full = (req_dbl >> last_q) >> 1;
    req_rot      = req_rot_full[N_MASTER-1:0];
  end

  // First requester after the pointer, converted back to a master index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = 0;
    for (int i = 0; i < int'(N_MASTER); i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_sum   = int'(last_q) + 1 + i;
        if (win_sum >= int'(N_MASTER)) win_sum = win_sum - int'(N_MASTER);
        win_idx   = OWN_W'(win_sum);
      end
    end
  end

  // Owner-relative views of request and lock.
  always_comb begin
    own_mask = N_MASTER'(1) << owner_q;
    own_req  = |(bus.m_req & own_mask);
    own_lock = |(bus.m_lock & own_mask);
    others   = |(bus.m_req & ~own_mask);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.m_req) take = 1'b1;
      end
      GRANT: begin
        if (!own_req) begin
          if (others) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_SAT)) &&
                     others && !own_lock) begin
          take = 1'b1;
        end else if (hold_q != HOLD_W'(HOLD_SAT)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    // Any new grant (first, handover or preemption) re-arms pointer and counter.
    if (take && win_found) begin
      state_d = GRANT;
      grant_d = N_MASTER'(1) << win_idx;
      owner_d = win_idx;
      last_d  = win_idx;
      hold_d  = '0;
    end
    busy_d = |grant_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OWN_W'(N_MASTER - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.m_grant = grant_q;
  assign bus.m_owner = owner_q;
  assign bus.m_busy  = busy_q;

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Testbench for bus_arbit_rr: a behavioural arbiter model predicts the
// grant for each driven cycle, the prediction is queued and compared once
// the DUT registers its output.
module tb_bus_arbit_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned MH = 16;
  localparam int unsigned OW = 2;

  typedef struct {
    logic [N-1:0] grant;
    int           owner;
    logic         busy;
  } exp_t;

  logic clk;
  logic reset_n;

  bus_arbit_rr_if #(.N_MASTER(N), .OWN_W(OW)) bus ();

  bus_arbit_rr #(.N_MASTER(N), .MAX_HOLD(MH), .OWN_W(OW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Model state
  int   md_owner, md_last, md_hold;
  logic md_busy;

  // Last observed values
  logic [N-1:0] obs_grant;
  int           obs_owner;
  logic         obs_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int from_last);
    for (int i = 1; i <= int'(N); i++) begin
      int idx;
      idx = (from_last + i) % int'(N);
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_new_grant(input logic [N-1:0] req);
    md_owner = rr_pick(req, md_last);
    md_last  = md_owner;
    md_hold  = 0;
    md_busy  = 1'b1;
  endtask

  task automatic model_reset();
    md_owner = 0;
    md_last  = int'(N) - 1;
    md_hold  = 0;
    md_busy  = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lock);
    logic [N-1:0] others;
    others = req;
    others[md_owner] = 1'b0;
    if (!md_busy) begin
      if (req != '0) model_new_grant(req);
    end else if (!req[md_owner]) begin
      if (others != '0) model_new_grant(req);
      else md_busy = 1'b0;
    end else if (MH != 0 && md_hold == int'(MH) - 1 && others != '0 && !lock[md_owner]) begin
      model_new_grant(req);
    end else if (md_hold < int'(MH) - 1) begin
      md_hold++;
    end
  endtask

  // Drive one cycle of inputs, queue the prediction, compare after the edge.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lock);
    exp_t e, got;
    @(negedge clk);
    bus.m_req  = req;
    bus.m_lock = lock;
    model_step(req, lock);
    e.grant = md_busy ? (N'(1) << md_owner) : '0;
    e.owner = md_owner;
    e.busy  = md_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs_grant = bus.m_grant;
    obs_owner = int'(bus.m_owner);
    obs_busy  = bus.m_busy;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(0), 32'(1));
    end else begin
      got = sb.pop_front();
      check("grant", 32'(obs_grant), 32'(got.grant));
      check("owner", 32'(obs_owner), 32'(got.owner));
      check("busy", 32'(obs_busy), 32'(got.busy));
      check("onehot0", 32'($onehot0(obs_grant)), 32'(1));
    end
  endtask

  task automatic do_reset(input logic [N-1:0] req);
    @(negedge clk);
    bus.m_req  = req;
    bus.m_lock = '0;
    reset_n    = 1'b0;
    model_reset();
    sb.delete();
    #1;
    check("rst_grant", 32'(bus.m_grant), 32'(0));
    check("rst_busy", 32'(bus.m_busy), 32'(0));
    check("rst_owner", 32'(bus.m_owner), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int cnt_a, cnt_b, idle_cnt;
    logic [N-1:0] req;
    reset_n    = 1'b0;
    bus.m_req  = '0;
    bus.m_lock = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset with all masters requesting, then master 0 first after release.
    do_reset(4'b1111);
    step(4'b1111, 4'b0000);
    check("rst_first_grant", 32'(obs_grant), 32'(4'b0001));

    // Single requester is never preempted.
    cnt_a = 0;
    repeat (40) begin
      step(4'b0100, 4'b0000);
      if (obs_grant == 4'b0100) cnt_a++;
    end
    check("single_cycles", 32'(cnt_a), 32'(40));
    check("single_owner", 32'(obs_owner), 32'(2));
    step(4'b0000, 4'b0000);
    check("single_release", 32'(obs_grant), 32'(0));

    // Round-robin order with release handover and no idle cycles.
    do_reset(4'b0000);
    idle_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      repeat (3) begin
        step(4'b1111, 4'b0000);
        if (!obs_busy) idle_cnt++;
      end
      check("rr_order", 32'(obs_owner), 32'(n % 4));
      req = 4'b1111;
      req[n % 4] = 1'b0;
      step(req, 4'b0000);
      if (!obs_busy) idle_cnt++;
    end
    check("rr_idle", 32'(idle_cnt), 32'(0));

    // Forced rotation after exactly MAX_HOLD cycles.
    do_reset(4'b0000);
    cnt_a = 0;
    cnt_b = 0;
    repeat (16) begin
      step(4'b0011, 4'b0000);
      if (obs_grant == 4'b0001) cnt_a++;
    end
    repeat (16) begin
      step(4'b0011, 4'b0000);
      if (obs_grant == 4'b0010) cnt_b++;
    end
    check("rot_m0_cycles", 32'(cnt_a), 32'(16));
    check("rot_m1_cycles", 32'(cnt_b), 32'(16));
    step(4'b0011, 4'b0000);
    check("rot_back_m0", 32'(obs_grant), 32'(4'b0001));

    // Lock holds the owner past the limit; dropping it rotates next edge.
    do_reset(4'b0000);
    cnt_a = 0;
    repeat (30) begin
      step(4'b0011, 4'b0001);
      if (obs_grant == 4'b0001) cnt_a++;
    end
    check("lock_cycles", 32'(cnt_a), 32'(30));
    step(4'b0011, 4'b0000);
    check("lock_release", 32'(obs_grant), 32'(4'b0010));

    // Asynchronous reset mid-grant.
    do_reset(4'b0000);
    repeat (3) step(4'b0100, 4'b0000);
    check("mid_owner", 32'(obs_owner), 32'(2));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.m_grant), 32'(0));
    check("async_busy", 32'(bus.m_busy), 32'(0));
    model_reset();
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1100, 4'b0000);
    check("post_rst_grant", 32'(obs_grant), 32'(4'b0100));

    // Random traffic against the model.
    repeat (400) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) req = req | obs_grant;
      step(req, 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbit_rr.md
Name: bus_arbit_rr

Overview:
- Parametrised multi-master bus arbiter; successor to the single-master request/grant arbiter.
- Arbitrates N_MASTER request lines onto one shared bus using round-robin fairness.
- Adds a hold limit that forces rotation, a per-master lock that blocks that rotation, and owner/busy status outputs.
- Sits between bus masters (CPU, DMA, …) and the bus mux; m_owner drives the mux select.

Parameters:
- N_MASTER, 4, number of requesting masters (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation when others wait; 0 disables preemption.
- OWN_W, 2, width of m_owner; must be at least ceil(log2(N_MASTER)).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- m_req  input  N_MASTER  request per master; level, held high for as long as the bus is wanted.
- m_lock  input  N_MASTER  per-master lock; while the owner's bit is high, preemption is suppressed.
- m_grant  output  N_MASTER  registered grant, one-hot or all-zero.
- m_owner  output  OWN_W  index of the granted master; holds the last owner's index while idle.
- m_busy  output  1  high when any m_grant bit is high.

Behaviour:
- Clocking and reset
  - One clock domain; reset is asynchronous and active-low.
  - On reset: m_grant=0, m_busy=0, m_owner=0, hold counter=0, state=IDLE, round-robin pointer last=N_MASTER-1 (so master 0 has first priority).
  - Assertion of reset_n low mid-grant drops the grant immediately (asynchronously), with no handover.
- Outputs and latency
  - All outputs are registered; no combinational path from m_req to m_grant.
  - Grant latency is 1 cycle: a request sampled at edge k appears on m_grant after edge k.
- State machine (2 states)
  - IDLE: no grant. If any m_req bit is high, move to GRANT and grant the winner.
    - Winner = first requester found scanning from (last+1) mod N_MASTER upward, wrapping.
  - GRANT, owner releases (m_req[owner]=0):
    - Other requesters present: grant moves to the next winner at the next edge; no idle cycle.
    - No other requesters: return to IDLE, m_grant=0.
  - GRANT, forced rotation: when MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, another master requests, and m_lock[owner]=0, the grant moves to the next winner at the next edge.
    - The owner is granted for exactly MAX_HOLD cycles.
    - The preempted owner keeps its request and re-enters the round-robin order.
  - GRANT, otherwise: hold the grant.
- Pointer and hold counter
  - last is updated to the new owner on every new grant, including a re-grant after IDLE.
  - hold_cnt clears to 0 on every new grant and increments each cycle the grant is held.
  - hold_cnt saturates at MAX_HOLD-1 (for example while locked or while alone).
- Lock release while waiting: if m_lock[owner] falls while hold_cnt is saturated and others request, rotation occurs at the next edge.
- Sole requester: never preempted, regardless of hold_cnt.
- Simultaneous release and new requests in the same cycle: handled as a release, with the winner chosen from requests sampled that cycle.
- Requests ignored: bits of m_req that are X, or masters beyond N_MASTER-1, are not required to be handled.
- Invariants: m_grant is always $onehot0; m_busy == |m_grant; m_owner == index of the set grant bit while busy.

Test Plan:
- Reset state: hold reset_n=0, drive m_req=4'b1111 → m_grant=0, m_busy=0. Release reset → m_grant=4'b0001 one cycle later.
- Single requester: m_req=4'b0100 for 40 cycles with MAX_HOLD=16 → m_grant=4'b0100 continuously, m_owner=2, no preemption. Drop m_req → m_grant=0 next cycle.
- Round-robin order: m_req=4'b1111, each owner drops its own req for 1 cycle after 3 cycles of grant → grant order 0,1,2,3,0 with zero idle cycles between grants.
- Forced rotation: MAX_HOLD=16, m_req=4'b0011 constant, m_lock=0 → master 0 granted exactly 16 cycles, then master 1 for 16, then master 0; m_grant onehot every cycle.
- Lock: as the forced-rotation case but m_lock=4'b0001 for 30 cycles → master 0 holds 30 cycles. Lock drops → grant moves to master 1 at the next edge.
- Reset mid-operation: assert reset_n=0 asynchronously mid-grant while owner=2 → m_grant=0 immediately. After release with m_req=4'b1100 → master 2 granted (pointer reset to 3, scan starts at 0).
